wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter N, default 64, datapath width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hold all stage state this cycle.
REQ-005 SHALL have port flush  input  1  discard the instruction entering this cycle.
REQ-006 SHALL have port in_valid  input  1  upstream (MEM) slot holds a real instruction.
REQ-007 SHALL have port in_regwrite  input  1  instruction writes a register.
REQ-008 SHALL have port in_memtoreg  input  1  1 = result from in_readdata, 0 = from in_aluresult.
REQ-009 SHALL have port in_wa  input  5  destination register index.
REQ-010 SHALL have port in_aluresult  input  N  ALU result.
REQ-011 SHALL have port in_readdata  input  N  data-memory load result.
REQ-012 SHALL have port ra1, ra2  input  5 each  register-file read addresses of the consuming stage.
REQ-013 SHALL have port we3  output  1  register-file write enable.
REQ-014 SHALL have port wa3  output  5  register-file write address.
REQ-015 SHALL have port wd3  output  N  register-file write data.
REQ-016 SHALL have port out_valid  output  1  stage holds a real instruction.
REQ-017 SHALL have port fwd1, fwd2  output  1 each  wd3 supersedes the register-file value for ra1 / ra2.
REQ-018 SHALL have port retired  output  32  count of instructions retired.

Function
REQ-019 SHALL capture all in_* fields on a rising clk edge when stall=0; latency in_* -> we3/wa3/wd3 is exactly 1 cycle.
REQ-020 SHALL hold every stage register unchanged on any edge with stall=1 and flush=0.
REQ-021 SHALL load out_valid=0 on any edge with flush=1, regardless of stall (flush has priority).
REQ-022 SHALL clear the captured regwrite bit whenever out_valid is loaded 0 (flush or in_valid=0).
REQ-023 SHALL drive we3 = out_valid AND captured regwrite AND (wa3 != 31); writes to X31 are suppressed.
REQ-024 SHALL drive wa3 = captured in_wa, even when we3=0.
REQ-025 SHALL drive wd3 = captured in_readdata if captured memtoreg=1, else captured in_aluresult; full N bits, no truncation.
REQ-026 SHALL increment retired by 1 on each edge where out_valid=1 and stall=0 and flush=0, counting each instruction exactly once.
REQ-027 SHALL wrap retired from 0xFFFFFFFF to 0x00000000 without any flag.
REQ-028 SHALL keep we3/wa3/wd3 stable for the whole duration of a stall, so the register file sees the same write repeatedly (an idempotent write).

Reset
REQ-029 SHALL on reset=0 immediately (asynchronously) force out_valid=0, captured regwrite=0, memtoreg=0, wa3=0, wd3=0, retired=0, and therefore we3=0, fwd1=0, fwd2=0.
REQ-030 SHALL keep all state at reset values while reset=0, independent of clk, stall and flush.
REQ-031 SHALL discard any captured instruction when reset asserts mid-operation, and SHALL NOT resume it after reset deasserts.

Configuration
REQ-032 SHALL support macro WB_STAGE_FWD_EN.
REQ-033 With WB_STAGE_FWD_EN defined, fwd1 SHALL equal we3 AND (ra1 == wa3) AND (ra1 != 31), combinationally; fwd2 SHALL be the same for ra2.
REQ-034 Without WB_STAGE_FWD_EN, fwd1 and fwd2 SHALL be constant 0 and the ra1/ra2 comparators SHALL be absent.

Verification
REQ-035 Reset then in_valid=1, regwrite=1, memtoreg=0, wa=5, alu=0x1234 -> next cycle we3=1, wa3=5, wd3=0x1234, retired increments to 1 on the following edge.
REQ-036 in_valid=1, regwrite=1, memtoreg=1, wa=9, readdata=0xFFFF_FFFF_FFFF_FFFF -> wd3=0xFFFF_FFFF_FFFF_FFFF, we3=1.
REQ-037 wa=31, regwrite=1 -> we3=0; with WB_STAGE_FWD_EN and ra1=31, fwd1=0.
REQ-038 Valid instruction captured, then stall=1 for 3 cycles -> we3/wa3/wd3 unchanged and retired unchanged; flush=1 with stall=1 -> out_valid=0 and we3=0 next cycle.
REQ-039 With WB_STAGE_FWD_EN, wa3=7, we3=1, ra1=7, ra2=8 -> fwd1=1, fwd2=0; without the macro -> fwd1=fwd2=0.
REQ-040 Preload retired=0xFFFFFFFF via 2^32-1 retirements (or forced state), retire one more -> retired=0; assert reset mid-stall -> all outputs 0 at once.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back pipeline stage: captures MEM results, drives the register-file write port,
// counts retirements. Define WB_STAGE_FWD_EN to enable the fwd1/fwd2 bypass comparators.
module wb_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         in_regwrite,
    input  logic         in_memtoreg,
    input  logic [4:0]   in_wa,
    input  logic [N-1:0] in_aluresult,
    input  logic [N-1:0] in_readdata,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    output logic         we3,
    output logic [4:0]   wa3,
    output logic [N-1:0] wd3,
    output logic         out_valid,
    output logic         fwd1,
    output logic         fwd2,
    output logic [31:0]  retired
);

    logic         valid_reg;
    logic         regwrite_reg;
    logic         memtoreg_reg;
    logic [4:0]   wa_reg;
    logic [N-1:0] alu_reg;
    logic [N-1:0] rdata_reg;
    logic [31:0]  retired_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            wa_reg       <= '0;
            alu_reg      <= '0;
            rdata_reg    <= '0;
            retired_reg  <= '0;
        end else begin
            // Flush only kills validity; payload fields are don't-care once invalid.
            if (flush) begin
                valid_reg    <= 1'b0;
                regwrite_reg <= 1'b0;
            end else if (!stall) begin
                valid_reg    <= in_valid;
                regwrite_reg <= in_valid & in_regwrite;
                memtoreg_reg <= in_memtoreg;
                wa_reg       <= in_wa;
                alu_reg      <= in_aluresult;
                rdata_reg    <= in_readdata;
            end
            // An instruction retires as it leaves the stage, so it is counted once.
            if (valid_reg && !stall && !flush)
                retired_reg <= retired_reg + 32'd1;
        end
    end

    assign out_valid = valid_reg;
    assign wa3       = wa_reg;
    assign wd3       = memtoreg_reg ? rdata_reg : alu_reg;
    assign we3       = valid_reg & regwrite_reg & (wa_reg != 5'd31);
    assign retired   = retired_reg;

`ifdef WB_STAGE_FWD_EN
    assign fwd1 = we3 & (ra1 == wa_reg) & (ra1 != 5'd31);
    assign fwd2 = we3 & (ra2 == wa_reg) & (ra2 != 5'd31);
`else
    logic unused_ra;
    assign unused_ra = ^{ra1, ra2};
    assign fwd1      = 1'b0;
    assign fwd2      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected stage state is pushed when inputs are driven
// and popped/compared one edge later.
module tb_wb_stage;

    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0, flush = 1'b0;
    logic         in_valid = 1'b0, in_regwrite = 1'b0, in_memtoreg = 1'b0;
    logic [4:0]   in_wa = '0, ra1 = '0, ra2 = '0;
    logic [N-1:0] in_aluresult = '0, in_readdata = '0;
    logic         we3, out_valid, fwd1, fwd2;
    logic [4:0]   wa3;
    logic [N-1:0] wd3;
    logic [31:0]  retired;

    int checks = 0;
    int failures = 0;

    wb_stage #(.N(N)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_wa(in_wa), .in_aluresult(in_aluresult), .in_readdata(in_readdata),
        .ra1(ra1), .ra2(ra2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .out_valid(out_valid),
        .fwd1(fwd1), .fwd2(fwd2), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         we;
        logic [4:0]   wa;
        logic [N-1:0] wd;
        logic         data_known;
        logic [31:0]  ret;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic         m_valid = 0, m_rw = 0, m_known = 1;
    logic [4:0]   m_wa = '0;
    logic [N-1:0] m_wd = '0;
    logic [31:0]  m_ret = '0;

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_fwd(input logic we, input logic [4:0] wa, input logic [4:0] ra);
`ifdef WB_STAGE_FWD_EN
        return we && (ra == wa) && (ra != 5'd31);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, ".out_valid"}, N'(out_valid), N'(e.valid));
        check_val({tag, ".we3"}, N'(we3), N'(e.we));
        check_val({tag, ".retired"}, N'(retired), N'(e.ret));
        check_val({tag, ".fwd1"}, N'(fwd1), N'(exp_fwd(e.we, e.wa, ra1)));
        check_val({tag, ".fwd2"}, N'(fwd2), N'(exp_fwd(e.we, e.wa, ra2)));
        if (e.data_known) begin
            check_val({tag, ".wa3"}, N'(wa3), N'(e.wa));
            check_val({tag, ".wd3"}, wd3, e.wd);
        end
    endtask

    // Drive one cycle, advance the model, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic st, input logic fl,
                        input logic v, input logic rw, input logic mtr, input logic [4:0] wa,
                        input logic [N-1:0] alu, input logic [N-1:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(negedge clk);
        stall = st; flush = fl; in_valid = v; in_regwrite = rw; in_memtoreg = mtr;
        in_wa = wa; in_aluresult = alu; in_readdata = rd; ra1 = r1; ra2 = r2;
        if (m_valid && !st && !fl) m_ret = m_ret + 32'd1;
        if (fl) begin
            m_valid = 0; m_rw = 0; m_known = 0;
        end else if (!st) begin
            m_valid = v; m_rw = v & rw; m_wa = wa; m_wd = mtr ? rd : alu; m_known = 1;
        end
        e.valid = m_valid; e.we = m_valid & m_rw & (m_wa != 5'd31);
        e.wa = m_wa; e.wd = m_wd; e.data_known = m_known; e.ret = m_ret;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        $display("txn %-10s st=%0b fl=%0b v=%0b wa=%0d -> we3=%0b wa3=%0d wd3=0x%0h valid=%0b ret=%0d",
                 tag, st, fl, v, wa, we3, wa3, wd3, out_valid, retired);
        check_outputs(tag, e);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".out_valid"}, N'(out_valid), '0);
        check_val({tag, ".we3"}, N'(we3), '0);
        check_val({tag, ".wa3"}, N'(wa3), '0);
        check_val({tag, ".wd3"}, wd3, '0);
        check_val({tag, ".retired"}, N'(retired), '0);
        check_val({tag, ".fwd1"}, N'(fwd1), '0);
        check_val({tag, ".fwd2"}, N'(fwd2), '0);
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_known = 1; m_wa = '0; m_wd = '0; m_ret = '0;
    endtask

    initial begin
        logic [N-1:0] ones;
        ones = '1;
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        step("basic",   0, 0, 1, 1, 0, 5'd5, 64'h1234, 64'hDEAD, 5'd5, 5'd6);
        step("bubble",  0, 0, 0, 1, 0, 5'd3, 64'h55, 64'h66, 5'd3, 5'd0);
        step("load",    0, 0, 1, 1, 1, 5'd9, 64'h77, ones, 5'd9, 5'd9);
        step("x31",     0, 0, 1, 1, 0, 5'd31, 64'hABCD, 64'h0, 5'd31, 5'd31);
        step("fwd",     0, 0, 1, 1, 0, 5'd7, 64'hCAFE_F00D_1234_5678, 64'h1, 5'd7, 5'd8);
        for (int i = 0; i < 3; i++)
            step("stall", 1, 0, 1, 1, 1, 5'd12, 64'h99, 64'h88, 5'd7, 5'd8);
        step("flushst", 1, 1, 1, 1, 0, 5'd13, 64'h1, 64'h2, 5'd13, 5'd7);
        step("nowr",    0, 0, 1, 0, 0, 5'd4, 64'h44, 64'h45, 5'd4, 5'd4);
        step("flush",   0, 1, 1, 1, 0, 5'd2, 64'h22, 64'h23, 5'd2, 5'd2);
        step("after",   0, 0, 1, 1, 1, 5'd1, 64'h10, 64'h11, 5'd1, 5'd3);

        for (int i = 0; i < 60; i++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), wa,
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 1) == 1) ? wa : 5'($urandom), 5'($urandom));
        end

        // Counter wrap: preload the counter just below the wrap point.
        step("prewrap", 0, 0, 1, 1, 0, 5'd6, 64'h6, 64'h0, 5'd6, 5'd0);
        #1;
        dut.retired_reg = 32'hFFFF_FFFF;
        m_ret = 32'hFFFF_FFFF;
        step("wrap", 0, 0, 1, 1, 0, 5'd8, 64'h8, 64'h0, 5'd8, 5'd0);
        step("postwrap", 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);

        // Asynchronous reset in the middle of a stall.
        step("prerst", 0, 0, 1, 1, 1, 5'd10, 64'h0, 64'hBEEF, 5'd10, 5'd10);
        step("rststall", 1, 0, 1, 1, 0, 5'd11, 64'h1, 64'h2, 5'd10, 5'd10);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            stall = 1'(i); flush = 1'(~i); in_valid = 1;
            @(posedge clk);
            #1 check_all_zero("held_rst");
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step("resume", 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);
        step("fresh",  0, 0, 1, 1, 0, 5'd3, 64'h33, 64'h0, 5'd3, 5'd4);
        step("fresh2", 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
